// File: rtl/regex_stream_scheduler.sv
// regex_stream_scheduler: shares one byte-serial regex engine between NUM_REQ
// stream requesters. Whole streams are granted round-robin and each is walked
// through the engine as clear -> bytes -> end-of-stream -> capture, after which
// one result record (id, match, start/end, length) is offered to the consumer.
// Optional feature macro: REGEX_SCHED_TIMEOUT_EN adds a stall watchdog that
// aborts a granted stream after TIMEOUT consecutive idle cycles (res_error=1).
module regex_stream_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int POS_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 m_reset,
  output logic                 m_en,
  output logic [7:0]           m_data,
  output logic                 m_streamEnd,
  input  logic                 m_rdy,
  input  logic                 m_match,
  input  logic [POS_W-1:0]     m_startPos,
  input  logic [POS_W-1:0]     m_endPos,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_match,
  output logic [POS_W-1:0]     res_start,
  output logic [POS_W-1:0]     res_end,
  output logic [POS_W-1:0]     res_len,
  output logic                 res_error
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || (2 ** ID_W) < NUM_REQ || TIMEOUT < 1) begin : g_param_err
    $error("regex_stream_scheduler: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_CAPTURE,
    S_REPORT
  } state_t;

  state_t            r_state;
  state_t            w_next;

  // r_grant doubles as the round-robin pointer: the last stream granted
  logic [ID_W-1:0]   r_grant;
  logic [ID_W-1:0]   w_pick;
  logic              w_any;
  int                w_best;
  int                w_dist;

  logic [POS_W-1:0]  r_len;
  logic [POS_W-1:0]  r_start;
  logic [POS_W-1:0]  r_end;
  logic              r_match;

  logic              w_gvalid;
  logic              w_glast;
  logic [7:0]        w_gdata;
  logic              w_hs;
  logic              w_cap;
  logic              w_timeout;
  logic              w_err;
  logic              w_rep;
  logic              w_ok;

  assign w_gvalid = req_valid[r_grant];
  assign w_glast  = req_last[r_grant];
  assign w_gdata  = req_data[{r_grant, 3'b000} +: 8];
  assign w_hs     = (r_state == S_STREAM) && w_gvalid;

  // Only the first qualified match of a stream is kept; later ones are ignored
  assign w_cap = ((r_state == S_STREAM) || (r_state == S_FLUSH) || (r_state == S_CAPTURE))
                 && m_rdy && m_match && !r_match;

  // Pick the waiting requester closest after the pointer (distance 0 = pointer+1)
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_best = NUM_REQ;
    w_dist = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - 1 - int'(r_grant)) % NUM_REQ;
      if (req_valid[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_pick = ID_W'(j);
        w_any  = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and engine/requester side outputs; everything quiet in reset
  always_comb begin
    w_next      = r_state;
    m_reset     = reset;
    m_en        = 1'b0;
    m_data      = 8'd0;
    m_streamEnd = 1'b0;
    req_ready   = '0;
    res_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (!reset) m_reset = 1'b1;
        w_next = S_STREAM;
      end
      S_STREAM: begin
        if (!reset) begin
          req_ready = NUM_REQ'(1) << r_grant;
          m_en      = w_gvalid;
          m_data    = w_gdata;
        end
        if ((w_hs && w_glast) || w_timeout) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (!reset) begin
          m_en        = 1'b1;
          m_streamEnd = 1'b1;
        end
        w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_next = S_REPORT;
      end
      S_REPORT: begin
        if (!reset) res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Grant pointer, byte counter and sticky first-match capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
      r_len   <= '0;
      r_match <= 1'b0;
      r_start <= '0;
      r_end   <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_any) begin
        r_grant <= w_pick;
      end
      if (r_state == S_CLEAR) begin
        r_len   <= '0;
        r_match <= 1'b0;
        r_start <= '0;
        r_end   <= '0;
      end else begin
        if (w_hs) r_len <= r_len + POS_W'(1);
        if (w_cap) begin
          r_match <= 1'b1;
          r_start <= m_startPos;
          r_end   <= m_endPos;
        end
      end
    end
  end

`ifdef REGEX_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] r_stall;
  logic               r_err;

  // The cycle that would be the TIMEOUT-th consecutive idle one ends the stream
  assign w_timeout = (r_state == S_STREAM) && !w_gvalid &&
                     (r_stall == STALL_W'(TIMEOUT - 1));
  assign w_err     = r_err;

  // Stall watchdog: counts consecutive idle cycles of the granted requester
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
      r_err   <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      r_stall <= '0;
      r_err   <= 1'b0;
    end else if (r_state == S_STREAM) begin
      if (w_hs) begin
        r_stall <= '0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end else begin
        r_stall <= r_stall + STALL_W'(1);
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_err     = 1'b0;
`endif

  // Result record is only driven while it is being offered; an aborted stream
  // never reports a match
  assign w_rep     = (r_state == S_REPORT) && !reset;
  assign w_ok      = w_rep && r_match && !w_err;
  assign res_id    = w_rep ? r_grant : '0;
  assign res_match = w_ok;
  assign res_start = w_ok ? r_start : '0;
  assign res_end   = w_ok ? r_end : '0;
  assign res_len   = w_rep ? r_len : '0;
  assign res_error = w_rep && w_err;

endmodule
